mem_arbiter: RTL and testbench

Two-master, one-slave arbiter that shares the single memory port between instruction fetch (master 0, read-only) and the load/store unit (master 1, read/write). The owner is granted in IDLE. The request is registered and presented to the memory. The response is routed back to the owner. Only one transaction is outstanding at a time. The block sits between IFU/Mstage and the memory model and replaces the separate fetch and data memory paths.

---
 rtl/mem_arbiter_if.sv | 31 +++
 rtl/mem_arbiter.sv | 115 +++++++++++
 tb/tb_mem_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter_if
//  Purpose  : Single-outstanding memory request/response bus shared by the
//             fetch unit, the load/store unit and the memory port.
//  Revision : 1.0  initial release
// ============================================================================
interface mem_arbiter_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [7:0]  wmask;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] rdata;

    // Requester side: issues requests, consumes responses
    modport master (
        output req_valid, addr, wen, wdata, wmask, resp_ready,
        input  req_ready, resp_valid, rdata
    );

    // Responder side: accepts requests, produces responses
    modport slave (
        input  req_valid, addr, wen, wdata, wmask, resp_ready,
        output req_ready, resp_valid, rdata
    );
endinterface : mem_arbiter_if
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Purpose  : Shares one memory port between instruction fetch (m0, reads
//             only) and the load/store unit (m1, reads and writes). One
//             transaction outstanding at a time; grants only from IDLE.
//  Revision : 1.0  initial release
// ============================================================================
module mem_arbiter #(
    parameter bit RR = 1'b1            // 1: round-robin, 0: m1 wins ties
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  m0_if,
    mem_arbiter_if.slave  m1_if,
    mem_arbiter_if.master s_if
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      state_q;
    logic        owner_q;              // master holding the bus
    logic        last_q;               // master granted most recently
    logic [31:0] addr_q;
    logic        wen_q;
    logic [31:0] wdata_q;
    logic [7:0]  wmask_q;

    logic        w_idle;
    logic        w_pick_m1;
    logic        w_gnt0;
    logic        w_gnt1;
    logic        w_resp_phase;
    logic        w_owner_ready;
    logic        w_unused_m0;

    // Fetch port carries no write payload; it is forced to zero on grant
    assign w_unused_m0 = ^{m0_if.wen, m0_if.wdata, m0_if.wmask};

    // Arbitration is only open in IDLE and never while reset is asserted,
    // so req_ready reads 0 during reset even though the state is IDLE.
    assign w_idle    = rst_n & (state_q == ST_IDLE);
    assign w_pick_m1 = m1_if.req_valid &
                       (~m0_if.req_valid | ~RR | ~last_q);
    assign w_gnt1    = w_idle & w_pick_m1;
    assign w_gnt0    = w_idle & m0_if.req_valid & ~w_pick_m1;

    assign m0_if.req_ready = w_gnt0;
    assign m1_if.req_ready = w_gnt1;

    // Memory request side is driven purely from the latched payload
    assign s_if.req_valid = (state_q == ST_REQ);
    assign s_if.addr      = addr_q;
    assign s_if.wen       = wen_q;
    assign s_if.wdata     = wdata_q;
    assign s_if.wmask     = wmask_q;

    // Response routing: only the owner sees resp_valid and drives back-pressure
    assign w_resp_phase    = (state_q == ST_RESP);
    assign w_owner_ready   = owner_q ? m1_if.resp_ready : m0_if.resp_ready;
    assign s_if.resp_ready = w_resp_phase & w_owner_ready;
    assign m0_if.resp_valid = w_resp_phase & ~owner_q & s_if.resp_valid;
    assign m1_if.resp_valid = w_resp_phase &  owner_q & s_if.resp_valid;

    // Read data is a straight pass-through qualified by resp_valid, except
    // that every output is held at zero while reset is asserted.
    assign m0_if.rdata = rst_n ? s_if.rdata : 32'h0;
    assign m1_if.rdata = rst_n ? s_if.rdata : 32'h0;

    // Transaction FSM: grant and latch in IDLE, present in REQ, route in RESP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;           // m0 wins the first round-robin tie
            addr_q  <= 32'h0;
            wen_q   <= 1'b0;
            wdata_q <= 32'h0;
            wmask_q <= 8'h0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_gnt0 || w_gnt1) begin
                        owner_q <= w_gnt1;
                        last_q  <= w_gnt1;
                        addr_q  <= w_gnt1 ? m1_if.addr : m0_if.addr;
                        wen_q   <= w_gnt1 & m1_if.wen;
                        wdata_q <= w_gnt1 ? m1_if.wdata : 32'h0;
                        wmask_q <= w_gnt1 ? m1_if.wmask : 8'h0;
                        state_q <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (s_if.req_ready) begin
                        state_q <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (s_if.resp_valid && w_owner_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_arbiter
//  Purpose  : Directed bench for mem_arbiter with a transaction-level
//             reference model compared on every falling edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

    localparam logic [31:0] C_F0_ADDR = 32'hA000_0000;
    localparam logic [31:0] C_F1_ADDR = 32'hB000_0000;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mem_arbiter_if m0_bus ();
    mem_arbiter_if m1_bus ();
    mem_arbiter_if s_bus ();
    mem_arbiter_if f0_bus ();
    mem_arbiter_if f1_bus ();
    mem_arbiter_if fs_bus ();

    mem_arbiter #(.RR(1'b1)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .m0_if (m0_bus),
        .m1_if (m1_bus),
        .s_if  (s_bus)
    );

    mem_arbiter #(.RR(1'b0)) u_dut_fp (
        .clk   (clk),
        .rst_n (rst_n),
        .m0_if (f0_bus),
        .m1_if (f1_bus),
        .s_if  (fs_bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] memfn(input logic [31:0] a);
        if (a == 32'h8000_0000) return 32'h0010_0073;
        return a ^ 32'hA5A5_0F0F;
    endfunction

    // ------------------------------------------------------------------
    // Reference model: one outstanding transaction, tracked as
    // "none / waiting for memory accept / waiting for response".
    // ------------------------------------------------------------------
    bit          md_busy  = 1'b0;
    bit          md_acc   = 1'b0;
    bit          md_owner = 1'b0;
    bit          md_last  = 1'b1;
    logic [31:0] md_addr  = 32'h0;
    logic        md_wen   = 1'b0;
    logic [31:0] md_wdata = 32'h0;
    logic [7:0]  md_wmask = 8'h0;

    always @(negedge clk) begin : p_model
        bit          win;
        bit          win1;
        logic        e_rr0, e_rr1, e_sv, e_srr, e_rv0, e_rv1;
        logic [31:0] e_rd;
        win  = 1'b0;
        win1 = 1'b0;
        if (!rst_n) begin
            md_busy = 0; md_acc = 0; md_owner = 0; md_last = 1;
            md_addr = 0; md_wen = 0; md_wdata = 0; md_wmask = 0;
            e_rr0 = 0; e_rr1 = 0; e_sv = 0; e_srr = 0; e_rv0 = 0; e_rv1 = 0;
            e_rd  = 32'h0;
        end else begin
            if (!md_busy && (m0_bus.req_valid || m1_bus.req_valid)) begin
                win = 1'b1;
                if (m0_bus.req_valid && m1_bus.req_valid) win1 = !md_last;
                else                                      win1 = m1_bus.req_valid;
            end
            e_rr0 = win & !win1;
            e_rr1 = win & win1;
            e_sv  = md_busy & !md_acc;
            e_srr = md_busy & md_acc & (md_owner ? m1_bus.resp_ready : m0_bus.resp_ready);
            e_rv0 = md_busy & md_acc & !md_owner & s_bus.resp_valid;
            e_rv1 = md_busy & md_acc &  md_owner & s_bus.resp_valid;
            e_rd  = s_bus.rdata;
        end
        check("mdl_m0_req_ready",  32'(m0_bus.req_ready),  32'(e_rr0));
        check("mdl_m1_req_ready",  32'(m1_bus.req_ready),  32'(e_rr1));
        check("mdl_s_req_valid",   32'(s_bus.req_valid),   32'(e_sv));
        check("mdl_s_addr",        s_bus.addr,             md_addr);
        check("mdl_s_wen",         32'(s_bus.wen),         32'(md_wen));
        check("mdl_s_wdata",       s_bus.wdata,            md_wdata);
        check("mdl_s_wmask",       32'(s_bus.wmask),       32'(md_wmask));
        check("mdl_s_resp_ready",  32'(s_bus.resp_ready),  32'(e_srr));
        check("mdl_m0_resp_valid", 32'(m0_bus.resp_valid), 32'(e_rv0));
        check("mdl_m1_resp_valid", 32'(m1_bus.resp_valid), 32'(e_rv1));
        check("mdl_m0_rdata",      m0_bus.rdata,           e_rd);
        check("mdl_m1_rdata",      m1_bus.rdata,           e_rd);
        if (rst_n) begin
            if (win) begin
                md_busy  = 1'b1;
                md_acc   = 1'b0;
                md_owner = win1;
                md_last  = win1;
                md_addr  = win1 ? m1_bus.addr : m0_bus.addr;
                md_wen   = win1 ? m1_bus.wen : 1'b0;
                md_wdata = win1 ? m1_bus.wdata : 32'h0;
                md_wmask = win1 ? m1_bus.wmask : 8'h0;
            end else if (md_busy && !md_acc) begin
                if (s_bus.req_ready) md_acc = 1'b1;
            end else if (md_busy && s_bus.resp_valid && e_srr) begin
                md_busy = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Cycle helpers: sample at the falling edge, drive after the rising edge
    // ------------------------------------------------------------------
    bit          acc_m, rsp_m, acc_f, rsp_f;
    logic [31:0] acc_addr_m, acc_addr_f;
    bit          f_owner = 1'b0;
    bit          grants[$];
    bit          fgrants[$];

    task automatic to_neg();
        @(negedge clk);
        acc_m      = s_bus.req_valid & s_bus.req_ready;
        rsp_m      = s_bus.resp_valid & s_bus.resp_ready;
        acc_addr_m = s_bus.addr;
        acc_f      = fs_bus.req_valid & fs_bus.req_ready;
        rsp_f      = fs_bus.resp_valid & fs_bus.resp_ready;
        acc_addr_f = fs_bus.addr;
        if (m0_bus.req_ready) grants.push_back(1'b0);
        if (m1_bus.req_ready) grants.push_back(1'b1);
        if (f0_bus.req_ready) begin fgrants.push_back(1'b0); f_owner = 1'b0; end
        if (f1_bus.req_ready) begin fgrants.push_back(1'b1); f_owner = 1'b1; end
        check("fp_m0_ready_vs_m1_valid", 32'(f0_bus.req_ready & f1_bus.req_valid), 32'h0);
        if (acc_f) check("fp_s_addr", acc_addr_f, f_owner ? C_F1_ADDR : C_F0_ADDR);
    endtask

    task automatic to_pos();
        @(posedge clk);
        #1;
        if (rsp_m) s_bus.resp_valid = 1'b0;
        if (acc_m) begin s_bus.resp_valid = 1'b1; s_bus.rdata = memfn(acc_addr_m); end
        if (rsp_f) fs_bus.resp_valid = 1'b0;
        if (acc_f) begin fs_bus.resp_valid = 1'b1; fs_bus.rdata = memfn(acc_addr_f); end
    endtask

    task automatic step();
        to_neg();
        to_pos();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_m0_req_ready"},  32'(m0_bus.req_ready),  32'h0);
        check({tag, "_m1_req_ready"},  32'(m1_bus.req_ready),  32'h0);
        check({tag, "_s_req_valid"},   32'(s_bus.req_valid),   32'h0);
        check({tag, "_s_addr"},        s_bus.addr,             32'h0);
        check({tag, "_s_resp_ready"},  32'(s_bus.resp_ready),  32'h0);
        check({tag, "_m0_resp_valid"}, 32'(m0_bus.resp_valid), 32'h0);
        check({tag, "_m1_resp_valid"}, 32'(m1_bus.resp_valid), 32'h0);
        check({tag, "_m0_rdata"},      m0_bus.rdata,           32'h0);
    endtask

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    initial begin
        rst_n = 1'b0;
        m0_bus.req_valid = 0; m0_bus.addr = 0; m0_bus.wen = 0; m0_bus.wdata = 0;
        m0_bus.wmask = 0; m0_bus.resp_ready = 1;
        m1_bus.req_valid = 0; m1_bus.addr = 0; m1_bus.wen = 0; m1_bus.wdata = 0;
        m1_bus.wmask = 0; m1_bus.resp_ready = 1;
        s_bus.req_ready = 1; s_bus.resp_valid = 0; s_bus.rdata = 0;
        f0_bus.req_valid = 0; f0_bus.addr = C_F0_ADDR; f0_bus.wen = 0; f0_bus.wdata = 0;
        f0_bus.wmask = 0; f0_bus.resp_ready = 1;
        f1_bus.req_valid = 0; f1_bus.addr = C_F1_ADDR; f1_bus.wen = 0; f1_bus.wdata = 0;
        f1_bus.wmask = 0; f1_bus.resp_ready = 1;
        fs_bus.req_ready = 1; fs_bus.resp_valid = 0; fs_bus.rdata = 0;

        // Reset with a fetch already pending: nothing may be granted
        m0_bus.req_valid = 1; m0_bus.addr = 32'h8000_0000;
        repeat (3) begin
            to_neg();
            check_zero("rst");
            to_pos();
        end
        rst_n = 1'b1;

        // Single zero-wait fetch
        to_neg();
        check("fetch_c0_m0_req_ready", 32'(m0_bus.req_ready), 32'h1);
        to_pos();
        m0_bus.req_valid = 0;
        to_neg();
        check("fetch_c1_s_req_valid", 32'(s_bus.req_valid), 32'h1);
        check("fetch_c1_s_addr", s_bus.addr, 32'h8000_0000);
        check("fetch_c1_s_wen", 32'(s_bus.wen), 32'h0);
        to_pos();
        to_neg();
        check("fetch_c2_m0_resp_valid", 32'(m0_bus.resp_valid), 32'h1);
        check("fetch_c2_m0_rdata", m0_bus.rdata, 32'h0010_0073);
        check("fetch_c2_m1_resp_valid", 32'(m1_bus.resp_valid), 32'h0);
        to_pos();
        m1_bus.req_valid = 1; m1_bus.addr = 32'h8000_0040;
        to_neg();
        check("fetch_c3_m1_req_ready", 32'(m1_bus.req_ready), 32'h1);
        to_pos();
        m1_bus.req_valid = 0;
        step(); step();

        // Tie: round-robin DUT alternates, fixed-priority DUT always picks m1
        grants.delete(); fgrants.delete();
        m0_bus.req_valid = 1; m0_bus.addr = 32'h1000_0000;
        m1_bus.req_valid = 1; m1_bus.addr = 32'h2000_0000;
        f0_bus.req_valid = 1; f1_bus.req_valid = 1;
        repeat (12) step();
        m0_bus.req_valid = 0; m1_bus.req_valid = 0;
        f0_bus.req_valid = 0; f1_bus.req_valid = 0;
        check("rr_grant_count", 32'(grants.size()), 32'd4);
        for (int i = 0; i < grants.size() && i < 4; i++)
            check($sformatf("rr_grant_%0d", i), 32'(grants[i]), 32'(i % 2));
        check("fp_grant_count", 32'(fgrants.size()), 32'd4);
        for (int i = 0; i < fgrants.size() && i < 4; i++)
            check($sformatf("fp_grant_%0d", i), 32'(fgrants[i]), 32'h1);

        // LSU write with request stalls and response back-pressure
        m1_bus.req_valid = 1; m1_bus.wen = 1; m1_bus.addr = 32'h8000_1000;
        m1_bus.wdata = 32'hDEAD_BEEF; m1_bus.wmask = 8'h0F;
        s_bus.req_ready = 0;
        to_neg();
        check("wr_m1_req_ready", 32'(m1_bus.req_ready), 32'h1);
        to_pos();
        m1_bus.req_valid = 0; m1_bus.wen = 0; m1_bus.addr = 32'hFFFF_FFFF;
        m1_bus.wdata = 32'h0; m1_bus.wmask = 8'h0;
        for (int i = 0; i < 4; i++) begin
            s_bus.req_ready = (i == 3);
            to_neg();
            check($sformatf("wr_hold%0d_s_req_valid", i), 32'(s_bus.req_valid), 32'h1);
            check($sformatf("wr_hold%0d_s_addr", i), s_bus.addr, 32'h8000_1000);
            check($sformatf("wr_hold%0d_s_wdata", i), s_bus.wdata, 32'hDEAD_BEEF);
            check($sformatf("wr_hold%0d_s_wmask", i), 32'(s_bus.wmask), 32'h0F);
            check($sformatf("wr_hold%0d_s_wen", i), 32'(s_bus.wen), 32'h1);
            to_pos();
        end
        m1_bus.resp_ready = 0;
        for (int i = 0; i < 2; i++) begin
            to_neg();
            check($sformatf("wr_bp%0d_m1_resp_valid", i), 32'(m1_bus.resp_valid), 32'h1);
            check($sformatf("wr_bp%0d_s_resp_ready", i), 32'(s_bus.resp_ready), 32'h0);
            to_pos();
        end
        m1_bus.resp_ready = 1;
        to_neg();
        check("wr_ack_m1_resp_valid", 32'(m1_bus.resp_valid), 32'h1);
        check("wr_ack_s_resp_ready", 32'(s_bus.resp_ready), 32'h1);
        check("wr_ack_m0_resp_valid", 32'(m0_bus.resp_valid), 32'h0);
        to_pos();
        step();

        // Asynchronous reset while a response is being presented
        m0_bus.req_valid = 1; m0_bus.addr = 32'h8000_0100;
        step();
        m0_bus.req_valid = 0;
        step();
        #2 rst_n = 1'b0;
        #1 check_zero("arst");
        to_neg();
        to_pos();
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            to_neg();
            check($sformatf("post%0d_m0_resp_valid", i), 32'(m0_bus.resp_valid), 32'h0);
            check($sformatf("post%0d_s_resp_ready", i), 32'(s_bus.resp_ready), 32'h0);
            check($sformatf("post%0d_s_req_valid", i), 32'(s_bus.req_valid), 32'h0);
            to_pos();
        end
        s_bus.resp_valid = 0;

        // Round-robin pointer restarted: m0 wins the first tie after reset
        m0_bus.req_valid = 1; m0_bus.addr = 32'h8000_0200;
        m1_bus.req_valid = 1; m1_bus.addr = 32'h8000_0300;
        to_neg();
        check("post_tie_m0_req_ready", 32'(m0_bus.req_ready), 32'h1);
        check("post_tie_m1_req_ready", 32'(m1_bus.req_ready), 32'h0);
        to_pos();
        m0_bus.req_valid = 0; m1_bus.req_valid = 0;
        step(); step(); step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_mem_arbiter
`default_nettype wire
